// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
//
// Owns the program counter and issues word-aligned requests to instruction memory. Responses
// come back in order; their addresses are recovered from a small in-flight address FIFO and the
// {instr, pc} pairs are buffered in an instruction queue that feeds decode. A redirect from
// execute reloads the PC, flushes the queue and marks every in-flight request as stale.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   imem_req_valid/ready/addr    fetch request channel (addr = current PC)
//   imem_rsp_valid/data          fetch response channel, in order, no backpressure
//   redirect, redirect_pc        taken branch/jump; redirect_pc[1:0] ignored
//   instr_valid/ready            handshake to decode
//   instr, instr_pc              instruction word and its address
module fetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  // Registered state
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [CntW-1:0]       out_q, out_d;
  logic [CntW-1:0]       drop_q, drop_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [PtrW-1:0]       af_wptr_q, af_wptr_d, af_rptr_q, af_rptr_d;
  logic [PtrW-1:0]       iq_wptr_q, iq_wptr_d, iq_rptr_q, iq_rptr_d;

  // Storage arrays (no reset needed; validity is tracked by the counters)
  logic [ADDR_WIDTH-1:0] af_addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] iq_data_q [DEPTH];
  logic [ADDR_WIDTH-1:0] iq_pc_q   [DEPTH];

  logic                  req_fire;
  logic                  rsp_accept;
  logic                  enq;
  logic                  deq;
  logic [ADDR_WIDTH-1:0] popped_addr;
  logic [CntW:0]         credit_used;

  logic unused_redirect_pc;
  assign unused_redirect_pc = ^redirect_pc[1:0];

  // Credit check uses registered counts only, so the request never depends on same-cycle inputs.
  assign credit_used    = {1'b0, out_q} + {1'b0, count_q};
  assign imem_req_valid = !rst && (credit_used < (CntW + 1)'(DEPTH));
  assign imem_req_addr  = pc_q;

  assign req_fire    = imem_req_valid && imem_req_ready;
  // A response with nothing outstanding (e.g. from before a reset) is ignored entirely.
  assign rsp_accept  = imem_rsp_valid && (out_q != '0);
  assign popped_addr = af_addr_q[af_rptr_q];
  assign enq         = rsp_accept && (drop_q == '0) && !redirect;

  assign instr_valid = (count_q != '0) && !redirect;
  assign deq         = instr_valid && instr_ready;
  assign instr       = (count_q != '0) ? iq_data_q[iq_rptr_q] : '0;
  assign instr_pc    = (count_q != '0) ? iq_pc_q[iq_rptr_q]   : '0;

  always_comb begin
    pc_d      = pc_q;
    out_d     = out_q + CntW'(req_fire) - CntW'(rsp_accept);
    drop_d    = drop_q;
    count_d   = count_q;
    af_wptr_d = af_wptr_q + PtrW'(req_fire);
    af_rptr_d = af_rptr_q + PtrW'(rsp_accept);
    iq_wptr_d = iq_wptr_q + PtrW'(enq);
    iq_rptr_d = iq_rptr_q + PtrW'(deq);

    if (redirect) begin
      pc_d      = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      count_d   = '0;
      iq_wptr_d = '0;
      iq_rptr_d = '0;
      // Everything still in flight after this edge (including a same-cycle request) is stale.
      drop_d    = out_d;
    end else begin
      if (req_fire) begin
        pc_d = pc_q + ADDR_WIDTH'(4);
      end
      if (rsp_accept && (drop_q != '0)) begin
        drop_d = drop_q - CntW'(1);
      end
      count_d = count_q + CntW'(enq) - CntW'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      out_q     <= '0;
      drop_q    <= '0;
      count_q   <= '0;
      af_wptr_q <= '0;
      af_rptr_q <= '0;
      iq_wptr_q <= '0;
      iq_rptr_q <= '0;
    end else begin
      pc_q      <= pc_d;
      out_q     <= out_d;
      drop_q    <= drop_d;
      count_q   <= count_d;
      af_wptr_q <= af_wptr_d;
      af_rptr_q <= af_rptr_d;
      iq_wptr_q <= iq_wptr_d;
      iq_rptr_q <= iq_rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) begin
      af_addr_q[af_wptr_q] <= pc_q;
    end
    if (enq && !rst) begin
      iq_data_q[iq_wptr_q] <= imem_rsp_data;
      iq_pc_q[iq_wptr_q]   <= popped_addr;
    end
  end

endmodule
